// File: rtl/cnt_run_ctrl_pkg.sv
// Shared types and widths for the counter run controller.
// No logic here; latency and backpressure do not apply.
package cnt_run_ctrl_pkg;

    localparam int RUNS_W = 8;
    localparam int LAT_W  = 16;

    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/cnt_run_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable); result visible 1 cycle later.
// No backpressure: counts whenever enabled, holds at all-ones.
module cnt_run_ctrl_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_run_ctrl.sv
// Drives counter enable, measures per-run latency and guards runs with a timeout; all outputs registered, 1-cycle response.
// No backpressure: i_start is dropped unless IDLE, i_abort always wins.
module cnt_run_ctrl
    import cnt_run_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int GAP_CYC     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [RUNS_W-1:0] i_nb_runs,
    input  logic              i_abort,
    output logic              o_en_cnt,
    input  logic              i_cnt_done,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_timeout,
    output logic [RUNS_W-1:0] o_runs_done,
    output logic [LAT_W-1:0]  o_last_latency
);

    localparam logic [LAT_W-1:0] TIMEOUT_V  = LAT_W'(TIMEOUT_CYC);
    localparam logic [LAT_W-1:0] GAP_LAST_V = LAT_W'(GAP_CYC - 1);

    state_e            state_q, state_d;
    logic [RUNS_W-1:0] nb_runs_q, nb_runs_d;
    logic [RUNS_W-1:0] runs_done_q, runs_done_d;
    logic [RUNS_W-1:0] runs_inc;
    logic [LAT_W-1:0]  last_lat_q, last_lat_d;
    logic              err_q, err_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              lat_en, gap_en;
    logic [LAT_W-1:0]  lat_cnt, lat_inc, gap_cnt;

    // Both counters sit at zero on the first cycle of their state.
    assign lat_en = (state_q == ST_RUN);
    assign gap_en = (state_q == ST_GAP);

    cnt_run_ctrl_sat_cnt #(.W(LAT_W)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!lat_en),
        .en    (lat_en),
        .cnt_o (lat_cnt)
    );

    cnt_run_ctrl_sat_cnt #(.W(LAT_W)) u_gap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!gap_en),
        .en    (gap_en),
        .cnt_o (gap_cnt)
    );

    // Latency including the current RUN cycle.
    assign lat_inc = (lat_cnt == LAT_MAX) ? LAT_MAX : lat_cnt + 1'b1;

    always_comb begin
        state_d     = state_q;
        nb_runs_d   = nb_runs_q;
        runs_done_d = runs_done_q;
        last_lat_d  = last_lat_q;
        err_d       = err_q;
        runs_inc    = runs_done_q + 1'b1;

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        nb_runs_d   = i_nb_runs;
                        runs_done_d = '0;
                        err_d       = 1'b0;
                        state_d     = (i_nb_runs == '0) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_cnt_done) begin
                        last_lat_d  = lat_inc;
                        runs_done_d = runs_inc;
                        state_d     = (runs_inc == nb_runs_q) ? ST_FINISH : ST_GAP;
                    end else if (lat_inc == TIMEOUT_V) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST_V) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        en_d   = (state_d == ST_RUN);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            nb_runs_q   <= '0;
            runs_done_q <= '0;
            last_lat_q  <= '0;
            err_q       <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nb_runs_q   <= nb_runs_d;
            runs_done_q <= runs_done_d;
            last_lat_q  <= last_lat_d;
            err_q       <= err_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_en_cnt       = en_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err_timeout  = err_q;
    assign o_runs_done    = runs_done_q;
    assign o_last_latency = last_lat_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Scoreboard bench for cnt_run_ctrl: a responder raises done after N enable cycles,
// monitors compare enable windows, gaps and end-of-sequence status against queued expectations.
module tb_cnt_run_ctrl;

    localparam int TMO = 20;
    localparam int GAP = 2;

    typedef struct {
        logic [7:0]  runs;
        logic [15:0] lat;
        logic        err;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_nb_runs;
    logic        i_abort;
    logic        o_en_cnt;
    logic        i_cnt_done;
    logic        o_busy;
    logic        o_done;
    logic        o_err_timeout;
    logic [7:0]  o_runs_done;
    logic [15:0] o_last_latency;

    int checks = 0;
    int errors = 0;
    int resp_n = 0;

    done_exp_t done_q[$];
    int        win_q[$];

    cnt_run_ctrl #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_nb_runs      (i_nb_runs),
        .i_abort        (i_abort),
        .o_en_cnt       (o_en_cnt),
        .i_cnt_done     (i_cnt_done),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err_timeout  (o_err_timeout),
        .o_runs_done    (o_runs_done),
        .o_last_latency (o_last_latency)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Responder: done is raised so that it is sampled on the resp_n-th enable cycle.
    initial begin
        int hi = 0;
        i_cnt_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_en_cnt) begin
                hi++;
                i_cnt_done = (resp_n != 0) && (hi == resp_n);
            end else begin
                hi = 0;
                i_cnt_done = 1'b0;
            end
        end
    end

    // Monitor: enable windows, gaps inside a sequence, and done pulses.
    initial begin
        int  win_len = 0;
        int  low_len = 0;
        bit  seen_win = 0;
        forever begin
            @(negedge clk);
            if (o_en_cnt) begin
                if (win_len == 0 && seen_win && o_busy)
                    check("gap_len", low_len, GAP);
                win_len++;
            end else begin
                if (win_len > 0) begin
                    if (win_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL win_unexpected: got window %0d expected none", win_len);
                    end else begin
                        check("win_len", win_len, win_q.pop_front());
                    end
                    seen_win = 1;
                    low_len  = 0;
                end
                win_len = 0;
                if (o_busy) begin
                    low_len++;
                end else begin
                    seen_win = 0;
                    low_len  = 0;
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done pulse expected none");
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    check("done_runs", int'(o_runs_done), int'(e.runs));
                    check("done_lat", int'(o_last_latency), int'(e.lat));
                    check("done_err", int'(o_err_timeout), int'(e.err));
                    check("done_busy", int'(o_busy), 1);
                end
            end
        end
    end

    task automatic push_done(input int runs, input int lat, input int err);
        done_exp_t e;
        e.runs = 8'(runs);
        e.lat  = 16'(lat);
        e.err  = err[0];
        done_q.push_back(e);
    endtask

    task automatic start_seq(input int nb, input int n);
        @(negedge clk);
        resp_n    = n;
        i_nb_runs = 8'(nb);
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL %s: busy still 1 expected 0 within 400 cycles", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_run2(input string name);
        int n = 0;
        while (!(o_en_cnt && o_runs_done == 8'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(o_en_cnt && o_runs_done == 8'd1)) begin
            errors++;
            $display("FAIL %s: second run not reached (runs_done %0d)", name, o_runs_done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   int'(o_en_cnt), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_err"},  int'(o_err_timeout), 0);
        check({tag, "_runs"}, int'(o_runs_done), 0);
        check({tag, "_lat"},  int'(o_last_latency), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_nb_runs = 8'd0;
        i_abort   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single run, done after 10 enable cycles.
        win_q.push_back(10);
        push_done(1, 10, 0);
        start_seq(1, 10);
        check("start_busy", int'(o_busy), 1);
        check("start_en", int'(o_en_cnt), 1);
        wait_idle("single");

        // Three runs of 5 cycles, with a start while busy that must be ignored.
        win_q.push_back(5); win_q.push_back(5); win_q.push_back(5);
        push_done(3, 5, 0);
        start_seq(3, 5);
        wait_run2("multi");
        i_nb_runs = 8'd7;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        wait_idle("multi");

        // Timeout: done never raised.
        win_q.push_back(TMO);
        push_done(0, 5, 1);
        start_seq(1, 0);
        wait_idle("timeout");
        check("err_sticky", int'(o_err_timeout), 1);

        // Done on the timeout cycle counts as success; new start clears the error.
        win_q.push_back(TMO);
        push_done(1, TMO, 0);
        start_seq(1, TMO);
        check("err_cleared", int'(o_err_timeout), 0);
        wait_idle("same_cycle");

        // Abort in the third cycle of run 2 of 4.
        win_q.push_back(6); win_q.push_back(3);
        start_seq(4, 6);
        wait_run2("abort");
        repeat (2) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_en", int'(o_en_cnt), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_runs", int'(o_runs_done), 1);
        check("abort_lat", int'(o_last_latency), 6);
        repeat (5) @(negedge clk);

        // Zero runs: done and busy for exactly one cycle.
        push_done(0, 6, 0);
        start_seq(0, 5);
        check("zero_busy_t1", int'(o_busy), 1);
        check("zero_done_t1", int'(o_done), 1);
        check("zero_en_t1", int'(o_en_cnt), 0);
        @(negedge clk);
        check("zero_busy_t2", int'(o_busy), 0);
        check("zero_done_t2", int'(o_done), 0);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the fifth cycle of a run.
        win_q.push_back(5);
        start_seq(2, 0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean sequence after reset.
        win_q.push_back(10);
        push_done(1, 10, 0);
        start_seq(1, 10);
        wait_idle("post_reset");

        check("done_q_empty", done_q.size(), 0);
        check("win_q_empty", win_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_run_ctrl.md
# cnt_run_ctrl

Run controller that drives the enable/done interface of the 8-bit counter (`counter_8b`) from the initiator side. It asserts the enable line, waits for the counter's done indication, and measures each run's latency in clock cycles. It repeats this for a programmed number of runs and guards each run with a timeout. It sits between a host/sequencer (start/abort, status) and one `counter_8b` instance.

## Interface
**Parameters**
- `TIMEOUT_CYC`, default 1000: max cycles enable may be high without done; range 1..65535.
- `GAP_CYC`, default 2: cycles enable is held low between runs; min 1.

**Ports**
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  one-cycle start request; honoured only in IDLE.
- `i_nb_runs`  in  8  number of runs; sampled with `i_start`.
- `i_abort`  in  1  synchronous abort, any state.
- `o_en_cnt`  out  1  enable to counter (`i_en_cnt` of `counter_8b`).
- `i_cnt_done`  in  1  done from counter (`o_cnt_done` of `counter_8b`); level-sampled.
- `o_busy`  out  1  high while a sequence is in progress.
- `o_done`  out  1  one-cycle pulse at end of sequence (normal or timeout).
- `o_err_timeout`  out  1  sticky; set on timeout, cleared by next accepted `i_start`.
- `o_runs_done`  out  8  runs completed in the current/last sequence.
- `o_last_latency`  out  16  enable-high cycles of the most recent completed run; saturates at 16'hFFFF.

## Operation
- **Reset** (async, `rst_n`=0): state IDLE; all outputs 0.
- **FSM states:** IDLE, RUN, GAP, FINISH.
- **IDLE:**
  - On `i_start`: latch `i_nb_runs`, clear `o_runs_done` and `o_err_timeout`.
  - If `i_nb_runs`=0, go to FINISH; else go to RUN.
- **RUN:**
  - `o_en_cnt`=1; the latency counter increments each cycle.
  - If `i_cnt_done`=1: store the latency in `o_last_latency` and increment `o_runs_done`.
    - Go to FINISH if this was the last run, else go to GAP.
  - Else if the latency count reaches `TIMEOUT_CYC`: set `o_err_timeout` and go to FINISH.
  - `i_cnt_done` has priority over timeout in the same cycle.
- **GAP:** `o_en_cnt`=0 for `GAP_CYC` cycles, then RUN. A `i_cnt_done` seen in GAP is ignored.
- **FINISH:** `o_done`=1 for one cycle, then IDLE.
- **Abort:** `i_abort` in any non-IDLE state returns to IDLE next cycle.
  - `o_en_cnt`=0 and `o_busy`=0 next cycle; no `o_done` pulse.
  - `o_runs_done` and `o_last_latency` are kept.
  - `i_abort` has priority over all other events. An `i_abort` coinciding with `i_start` in IDLE leaves the block in IDLE.
- **Ignored inputs:** `i_start` while busy is ignored; the latched run count is unaffected.
- **Width rules:**
  - `o_runs_done` cannot wrap, since it never exceeds `i_nb_runs` (max 255).
  - The latency counter is 16 bits and saturating.

## Timing
- All outputs are registered.
- Start:
  - `i_start` accepted at edge t gives `o_busy`=1 and `o_en_cnt`=1 from t+1 (first RUN cycle).
  - With `i_nb_runs`=0: `o_busy`=1 and `o_done`=1 at t+1 only; both 0 at t+2.
- Run completion:
  - `i_cnt_done` sampled high at edge k gives `o_en_cnt`=0, updated `o_runs_done` and updated `o_last_latency` at k+1.
  - Latency = number of cycles with `o_en_cnt`=1, including cycle k.
- Between runs: after `GAP_CYC` low cycles, `o_en_cnt` rises again.
- Last run or timeout:
  - `o_done`=1 in the cycle after the event; `o_busy`=1 through the `o_done` cycle and 0 the cycle after.
  - `o_err_timeout` becomes valid with `o_done`.
- Back-to-back: a new `i_start` is accepted in the first IDLE cycle after `o_done`.
- Reset mid-run: outputs drop to 0 immediately (async); the next sequence starts clean.

## Structure
- Package `cnt_run_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/GAP/FINISH);
  - width constants `RUNS_W`=8 and `LAT_W`=16;
  - the saturation constant `LAT_MAX`.
- Sub-module `cnt_run_ctrl_sat_cnt`: a parameterised saturating up-counter with clear and enable.
  - One instance serves as the latency/timeout counter.
  - One instance serves as the GAP counter.
- The FSM and status registers live in the top module.

## Test plan
- **Single run:** `i_nb_runs`=1, responder raises done 10 cycles after enable rises → `o_last_latency`=10, `o_runs_done`=1, one `o_done` pulse, `o_err_timeout`=0, `o_en_cnt` high exactly 10 cycles.
- **Multi-run with gap:** `i_nb_runs`=3, `GAP_CYC`=2, done after 5 cycles → three 5-cycle enable windows separated by exactly 2 low cycles, `o_runs_done`=3, one `o_done` pulse. With the real `counter_8b` instead, check latency against its documented terminal count.
- **Timeout:** `TIMEOUT_CYC`=20, done never raised → `o_en_cnt` low after 20 cycles, `o_err_timeout`=1, `o_done` pulse, `o_runs_done`=0. The next `i_start` clears the error.
- **Done and timeout in the same cycle:** done raised on cycle 20 with `TIMEOUT_CYC`=20 → counted as success, latency 20, no error.
- **Abort and ignored start:** `i_abort` in run 2 of 4 → IDLE next cycle, no `o_done`, `o_runs_done`=1. `i_start` while busy causes no effect.
- **Zero runs and reset:** `i_nb_runs`=0 → `o_done` at t+1 and `o_en_cnt` never high. Asserting `rst_n`=0 mid-RUN → all outputs 0 asynchronously.
